// File: rtl/key_debounce_if.sv
// Key bundle between the push-button pads and the debouncer.
// The master drives the raw active-low keys; the slave returns the debounced state and pulses.
interface key_debounce_if #(
  parameter int unsigned NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;

  modport master (output key_n, input key_level, input key_press, input key_release);
  modport slave  (input key_n, output key_level, output key_press, output key_release);
endinterface

// File: rtl/key_debounce.sv
// Multi-channel push-button debouncer: 2-flop synchronizers, one shared 1 ms tick,
// and a per-key FSM that requires DEBOUNCE_MS stable ticks before accepting an edge.
module key_debounce #(
  parameter int unsigned TICK_CYCLES = 25000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned NUM_KEYS    = 4
) (
  input  logic          clk_25mhz,
  input  logic          rst,
  key_debounce_if.slave keys
);

  localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned MS_W   = 5;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(DEBOUNCE_MS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] raw_pressed;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic [NUM_KEYS-1:0] level_q;
  logic [NUM_KEYS-1:0] press_q;
  logic [NUM_KEYS-1:0] release_q;

  // Synchronizers reset to the released level so reset never looks like a press.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= keys.key_n;
      sync2 <= sync1;
    end
  end

  assign raw_pressed = ~sync2;

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    state_e          state_q;
    logic [MS_W-1:0] ms_cnt;
    logic            level_r;
    logic            press_r;
    logic            release_r;

    // Raw edges are tested before the tick so a coincident edge restarts the window.
    always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) begin
        state_q   <= IDLE;
        ms_cnt    <= '0;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        case (state_q)
          IDLE: begin
            if (raw_pressed[g]) begin
              state_q <= PRESS_WAIT;
              ms_cnt  <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!raw_pressed[g]) begin
              state_q <= IDLE;
            end else if (tick) begin
              if (ms_cnt == MS_LAST) begin
                state_q <= PRESSED;
                ms_cnt  <= '0;
                level_r <= 1'b1;
                press_r <= 1'b1;
              end else begin
                ms_cnt <= ms_cnt + MS_W'(1);
              end
            end
          end
          PRESSED: begin
            if (!raw_pressed[g]) begin
              state_q <= RELEASE_WAIT;
              ms_cnt  <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (raw_pressed[g]) begin
              state_q <= PRESSED;
            end else if (tick) begin
              if (ms_cnt == MS_LAST) begin
                state_q   <= IDLE;
                ms_cnt    <= '0;
                level_r   <= 1'b0;
                release_r <= 1'b1;
              end else begin
                ms_cnt <= ms_cnt + MS_W'(1);
              end
            end
          end
          default: begin
            state_q <= IDLE;
            ms_cnt  <= '0;
            level_r <= 1'b0;
          end
        endcase
      end
    end

    assign level_q[g]   = level_r;
    assign press_q[g]   = press_r;
    assign release_q[g] = release_r;
  end

  assign keys.key_level   = level_q;
  assign keys.key_press   = press_q;
  assign keys.key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with a 10-cycle tick and a 4 ms window:
// expected pulses are queued at stimulus time and matched by a monitor on every falling edge.
module tb_key_debounce;

  localparam int unsigned TICK_CYCLES = 10;
  localparam int unsigned DEBOUNCE_MS = 4;
  localparam int unsigned NUM_KEYS    = 4;
  localparam int          LAT_MIN     = 33;
  localparam int          LAT_MAX     = 43;

  typedef struct {
    logic [3:0] press;
    logic [3:0] rel;
    int         lo;
    int         hi;
  } exp_t;

  logic clk_25mhz = 1'b0;
  logic rst       = 1'b1;
  int   cyc       = 0;
  int   errors    = 0;
  int   checks    = 0;
  exp_t sb[$];

  key_debounce_if #(.NUM_KEYS(NUM_KEYS)) kif ();

  key_debounce #(
    .TICK_CYCLES(TICK_CYCLES),
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .NUM_KEYS   (NUM_KEYS)
  ) dut (
    .clk_25mhz(clk_25mhz),
    .rst      (rst),
    .keys     (kif)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  always @(posedge clk_25mhz) cyc++;

  // Every pulse must match the oldest queued expectation in value and timing.
  always @(negedge clk_25mhz) begin
    if (!rst && (kif.key_press !== 4'b0000 || kif.key_release !== 4'b0000)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b required none",
                 cyc, kif.key_press, kif.key_release);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks += 2;
        if (kif.key_press !== e.press || kif.key_release !== e.rel) begin
          errors++;
          $display("FAIL pulse_value cyc=%0d press=%b release=%b required press=%b release=%b",
                   cyc, kif.key_press, kif.key_release, e.press, e.rel);
        end
        if (cyc < e.lo || cyc > e.hi) begin
          errors++;
          $display("FAIL pulse_time cyc=%0d required %0d..%0d", cyc, e.lo, e.hi);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  task automatic expect_pulse(input logic [3:0] press, input logic [3:0] rel);
    exp_t e;
    e.press = press;
    e.rel   = rel;
    e.lo    = cyc + LAT_MIN;
    e.hi    = cyc + LAT_MAX;
    sb.push_back(e);
  endtask

  task automatic check_level(input string name, input logic [3:0] want);
    checks++;
    if (kif.key_level !== want) begin
      errors++;
      $display("FAIL %s key_level=%b required %b", name, kif.key_level, want);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s missing %0d expected pulse(s), got 0 of them", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    kif.key_n = 4'b0000;
    rst = 1'b1;
    wait_cycles(4);
    checks += 2;
    if (kif.key_level !== 4'b0000) begin
      errors++;
      $display("FAIL reset_level key_level=%b required 0000", kif.key_level);
    end
    if (kif.key_press !== 4'b0000 || kif.key_release !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulses press=%b release=%b required 0000/0000",
               kif.key_press, kif.key_release);
    end
    kif.key_n = 4'b1111;
    rst = 1'b0;
    wait_cycles(10);
    check_level("reset_idle", 4'b0000);
  endtask

  task automatic test_single_press;
    kif.key_n = 4'b1110;
    expect_pulse(4'b0001, 4'b0000);
    wait_cycles(30);
    check_level("press_early", 4'b0000);
    wait_cycles(20);
    check_level("press_level", 4'b0001);
    check_drained("press_single");
  endtask

  task automatic test_release;
    kif.key_n = 4'b1111;
    expect_pulse(4'b0000, 4'b0001);
    wait_cycles(30);
    check_level("release_early", 4'b0001);
    wait_cycles(20);
    check_level("release_level", 4'b0000);
    check_drained("release_single");
  endtask

  task automatic test_bounce;
    for (int k = 0; k < 14; k++) begin
      kif.key_n[1] = k[0];
      wait_cycles(15);
    end
    check_level("bounce_level", 4'b0000);
    check_drained("bounce_quiet");
    kif.key_n[1] = 1'b0;
    expect_pulse(4'b0010, 4'b0000);
    wait_cycles(50);
    check_level("bounce_final", 4'b0010);
    check_drained("bounce_press");
    kif.key_n[1] = 1'b1;
    expect_pulse(4'b0000, 4'b0010);
    wait_cycles(50);
    check_drained("bounce_release");
  endtask

  task automatic test_release_bounce;
    kif.key_n[0] = 1'b0;
    expect_pulse(4'b0001, 4'b0000);
    wait_cycles(50);
    check_drained("rbounce_press");
    kif.key_n[0] = 1'b1;
    wait_cycles(20);
    check_level("rbounce_mid", 4'b0001);
    wait_cycles(5);
    kif.key_n[0] = 1'b0;
    wait_cycles(60);
    check_level("rbounce_held", 4'b0001);
    check_drained("rbounce_no_release");
    kif.key_n[0] = 1'b1;
    expect_pulse(4'b0000, 4'b0001);
    wait_cycles(50);
    check_level("rbounce_done", 4'b0000);
    check_drained("rbounce_release");
  endtask

  task automatic test_simultaneous;
    kif.key_n = 4'b0011;
    expect_pulse(4'b1100, 4'b0000);
    wait_cycles(50);
    check_level("simul_level", 4'b1100);
    check_drained("simul_press");
    kif.key_n = 4'b1111;
    expect_pulse(4'b0000, 4'b1100);
    wait_cycles(50);
    check_level("simul_idle", 4'b0000);
    check_drained("simul_release");
  endtask

  task automatic test_reset_mid;
    kif.key_n = 4'b1110;
    expect_pulse(4'b0001, 4'b0000);
    wait_cycles(50);
    check_drained("rmid_press");
    rst = 1'b1;
    #1;
    check_level("rmid_async", 4'b0000);
    checks++;
    if (kif.key_press !== 4'b0000 || kif.key_release !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_pulses press=%b release=%b required 0000/0000",
               kif.key_press, kif.key_release);
    end
    wait_cycles(3);
    rst = 1'b0;
    expect_pulse(4'b0001, 4'b0000);
    wait_cycles(30);
    check_level("rmid_rewindow", 4'b0000);
    wait_cycles(20);
    check_level("rmid_level", 4'b0001);
    check_drained("rmid_repress");
    kif.key_n = 4'b1111;
    expect_pulse(4'b0000, 4'b0001);
    wait_cycles(50);
    check_drained("rmid_release");
  endtask

  initial begin
    kif.key_n = 4'b1111;
    @(negedge clk_25mhz);
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid();
    wait_cycles(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
